// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched entries; entry 0 is always the head.
module fetch_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q;
  logic [W-1:0] e1_q;
  logic [1:0]   cnt_q;
  logic         do_pop;
  logic         do_push;

  // A pop on an empty buffer is a no-op; a push into a full buffer only
  // lands when a pop frees the head in the same cycle.
  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  assign head  = e0_q;
  assign count = cnt_q;

  // Entry storage and occupancy; flush only clears occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= push_data;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_data;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= push_data;
          else               e1_q <= push_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, fetch/redirect control and a
// two-entry output buffer toward decode.
// Optional build macro BBQ_FETCH_MISALIGN_EN: misaligned redirects are kept
// unmasked and produce a single faulting NOP entry (out_fault port).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
`ifdef BBQ_FETCH_MISALIGN_EN
  ,
  output logic            out_fault
`endif
);

`ifdef BBQ_FETCH_MISALIGN_EN
  localparam int EW = 2 * XLEN + 1;
`else
  localparam int EW = 2 * XLEN;
`endif

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redirect_target;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head;
  logic [1:0]      count;
  logic            pop;
  logic            fire;
  logic            push;
  logic            advance;

  assign imem_addr = pc_q;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign fire      = !redirect_valid && ((count < 2'd2) || pop);

`ifdef BBQ_FETCH_MISALIGN_EN
  logic fault_q;
  logic fault_pushed_q;

  // While faulted, only the single NOP entry is pushed and the PC freezes.
  assign redirect_target = redirect_pc;
  assign push            = fire && (!fault_q || !fault_pushed_q);
  assign advance         = fire && !fault_q;
  assign push_data       = fault_q ? {1'b1, pc_q, INST_NOP}
                                   : {1'b0, pc_q, imem_rdata};
  assign out_fault       = out_valid && head[EW-1];

  // Sticky fault flag, re-evaluated on every redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q        <= 1'b0;
      fault_pushed_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q        <= (redirect_pc[1:0] != 2'b00);
      fault_pushed_q <= 1'b0;
    end else if (push && fault_q) begin
      fault_pushed_q <= 1'b1;
    end
  end
`else
  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign push            = fire;
  assign advance         = fire;
  assign push_data       = {pc_q, imem_rdata};
`endif

  assign out_pc   = head[2*XLEN-1:XLEN];
  assign out_inst = head[XLEN-1:0];

  // PC: redirect has priority over sequential advance; wraps modulo 2^XLEN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= redirect_target;
    else if (advance)        pc_q <= pc_q + PC_STEP;
  end

  fetch_buf #(.W(EW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational imem model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef BBQ_FETCH_MISALIGN_EN
  logic        out_fault;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:16] ^ 16'hC0DE, a[15:0] ^ 16'h3A5C};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
`ifdef BBQ_FETCH_MISALIGN_EN
    ,
    .out_fault      (out_fault)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_inst"}, out_inst, mem_word(pc));
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    // reset state
    step();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_addr", imem_addr, 32'h100);
`ifdef BBQ_FETCH_MISALIGN_EN
    chk("rst_fault", {31'b0, out_fault}, 32'd0);
`endif

    // streaming with ready high
    reset = 1'b0;
    out_ready = 1'b1;
    step(); chk_head("s1", 32'h100);
    step(); chk_head("s2", 32'h104);
    step(); chk_head("s3", 32'h108);

    // stall fills the buffer, release drains it without gaps
    reset = 1'b1; step(); reset = 1'b0;
    step(); chk_head("st1", 32'h100);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_head("st_hold", 32'h100);
    chk("st_addr", imem_addr, 32'h108);
    out_ready = 1'b1;
    step(); chk_head("rl1", 32'h104);
    step(); chk_head("rl2", 32'h108);
    step(); chk_head("rl3", 32'h10C);

    // redirect while full and stalled
    out_ready = 1'b0;
    step(); step(); step();
    do_redirect(32'h40);
    chk("rd_valid", {31'b0, out_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'h40);
    step(); chk_head("rd1", 32'h40);
    out_ready = 1'b1;
    step(); chk_head("rd2", 32'h44);

    // wraparound
    do_redirect(32'hFFFF_FFF8);
    chk("wr_gap", {31'b0, out_valid}, 32'd0);
    step(); chk_head("wr1", 32'hFFFF_FFF8);
    step(); chk_head("wr2", 32'hFFFF_FFFC);
    step(); chk_head("wr3", 32'h0000_0000);

    // asynchronous reset mid-stream
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_pc", out_pc, 32'h0);
    chk("ar_addr", imem_addr, 32'h100);
    step();
    reset = 1'b0;
    step(); chk_head("ar1", 32'h100);
    step(); chk_head("ar2", 32'h104);

    // misaligned redirect
    do_redirect(32'h42);
    chk("ma_gap", {31'b0, out_valid}, 32'd0);
    step();
`ifdef BBQ_FETCH_MISALIGN_EN
    chk("ma_valid", {31'b0, out_valid}, 32'd1);
    chk("ma_pc", out_pc, 32'h42);
    chk("ma_inst", out_inst, 32'h13);
    chk("ma_fault", {31'b0, out_fault}, 32'd1);
    step();
    chk("ma_stop1", {31'b0, out_valid}, 32'd0);
    step();
    chk("ma_stop2", {31'b0, out_valid}, 32'd0);
    chk("ma_addr", imem_addr, 32'h42);
    do_redirect(32'h80);
    step(); chk_head("ma_clr", 32'h80);
    chk("ma_clr_fault", {31'b0, out_fault}, 32'd0);
`else
    chk_head("ma_mask", 32'h40);
    step(); chk_head("ma_next", 32'h44);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction memory.
- Holds the PC and drives the combinational imem read address. Captures {pc, inst} pairs into a 2-entry buffer and presents them to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) from the execute stage by flushing and reloading the PC.

Parameters:
- RESET_PC, 0, PC loaded on reset; must be 4-byte aligned.
- XLEN, from constants.vh (32), data/address width; not overridden per instance.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  XLEN  byte address to imem; imem returns the word combinationally in the same cycle.
- imem_rdata  input  XLEN  instruction word for imem_addr.
- redirect_valid  input  1  one-cycle pulse: fetch must resume at redirect_pc.
- redirect_pc  input  XLEN  redirect target.
- out_valid  output  1  head buffer entry is valid.
- out_ready  input  1  decode accepts the head entry this cycle.
- out_pc  output  XLEN  PC of the head entry.
- out_inst  output  XLEN  instruction word of the head entry.
- out_fault  output  1  present only with BBQ_FETCH_MISALIGN_EN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, buffer count=0, out_valid=0, out_pc=0, out_inst=0, out_fault=0.
- imem_addr = pc at all times.
- Fetch condition: fire = !redirect_valid && (count<2 || pop), where pop = out_valid && out_ready.
- On fire: push {pc, imem_rdata} into the buffer; pc <= pc + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0, no flag).
- When the buffer is full and there is no pop: no push and pc holds. The imem word is discarded and re-read later, which is harmless because imem is side-effect free.
- Buffer: 2-entry FIFO, head presented on out_*.
  - Push and pop in the same cycle are legal at every count; count is unchanged.
  - out_valid = (count!=0).
  - out_pc/out_inst hold their value while out_valid && !out_ready.
- Latency: reset deassert (cycle 0) -> out_valid=1 with out_pc=RESET_PC at cycle 1. With out_ready held high, throughput is 1 instruction/cycle.
- Redirect (highest priority):
  - Buffer flushes (count<=0); pc <=(redirect_pc & ~3); no push that cycle.
  - A pop in the same cycle is treated as accepted; decode must squash it itself.
  - out_valid=0 at cycle+1; target instruction appears at cycle+2.
- Back-to-back redirects: the last one wins; each cycle reloads pc.
- Reset mid-operation: all state returns to reset values immediately (async). The first fetch happens on the first edge after deassert.
- Empty buffer with out_ready=1: no effect.

Optional Feature:
- BBQ_FETCH_MISALIGN_EN
  - Defined:
    - A redirect with redirect_pc[1:0]!=0 loads pc <= redirect_pc unmasked and sets a sticky fault flag.
    - While faulted, pc does not advance. Exactly one entry {pc, 0x00000013 NOP} is pushed, and its out_fault is 1.
    - Further fetch stops until the next redirect or reset clears the flag.
    - out_fault is per-entry (stored in the buffer), 0 for normal entries.
  - Undefined: redirect_pc[1:0] is silently cleared; there is no out_fault port.

Decomposition:
- constants.vh (shared): XLEN, ILEN, INST_NOP (0x00000013), PC_STEP (4).
- Sub-module fetch_buf: 2-entry FIFO parameterized by entry width.
  - Ports: clk, reset, flush, push, push_data, pop, head, count.
  - fetch_unit contains the PC register, fire logic and redirect mux.

Test Plan:
- Reset, RESET_PC=0x100, out_ready=1 -> out_pc = 0x100, 0x104, 0x108 on cycles 1, 2, 3, each with out_inst=mem[pc>>2].
- out_ready=0 for 5 cycles after cycle 1 -> count saturates at 2, pc holds at 0x108, out_pc stays 0x100. Releasing ready yields 0x100, 0x104, 0x108 with no gap or duplicate.
- redirect_valid with redirect_pc=0x40 while full and stalled -> out_valid=0 next cycle, out_pc=0x40 the cycle after, old entries never appear.
- pc=0xFFFFFFF8, ready=1 -> out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset asserted mid-stream between edges -> out_valid drops immediately. After deassert the sequence restarts at RESET_PC.
- Misaligned redirect to 0x42:
  - With BBQ_FETCH_MISALIGN_EN: one entry, out_pc=0x42, out_inst=0x00000013, out_fault=1, then no output until the next redirect.
  - Without it: out_pc=0x40.
